// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin write-back arbiter for the 6-input register-file
// write-data mux (mux_WD). Issues at most one registered grant per cycle and
// drives the mux selector, write enable and write address.
// Optional build macro: WB_LOAD_PRIORITY_EN (mem-load requester 1 always wins
// when eligible). When undefined, all six requesters are pure round-robin.
module wb_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  req,
   input  logic [29:0] waddr,
   input  logic        wb_stall,
   output logic [5:0]  gnt,
   output logic [2:0]  wd_sel,
   output logic        reg_wr,
   output logic [4:0]  wr_addr,
   output logic        busy
);

   localparam int unsigned N_REQ  = 6;
   localparam int unsigned ADDR_W = 5;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] STALL = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [2:0]        last_ptr;
   logic [N_REQ-1:0]  elig;
   logic [2:0]        winner;
   logic              found;
   logic              issue;
   logic [ADDR_W-1:0] sel_addr;

   // A requester is masked in the cycle its own grant is high.
   assign elig  = req & ~gnt;
   assign issue = found & ~wb_stall;

   // Round-robin search starting just after the last winner, wrapping 5 -> 0.
   always_comb begin
      logic [3:0] cand;
      winner = 3'd0;
      found  = 1'b0;
      cand   = 4'd0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = 4'({1'b0, last_ptr}) + 4'(k);
         if (cand >= 4'(N_REQ)) begin
            cand = cand - 4'(N_REQ);
         end
         if (!found && elig[cand[2:0]]) begin
            found  = 1'b1;
            winner = cand[2:0];
         end
      end
`ifdef WB_LOAD_PRIORITY_EN
      if (elig[1]) begin
         found  = 1'b1;
         winner = 3'd1;
      end
`endif
   end

   // Destination register of the selected requester.
   assign sel_addr = waddr[ADDR_W*32'(winner) +: ADDR_W];

   // Next-state logic: a stall only blocks the next issue.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (issue) state_next = GRANT;
            else       state_next = IDLE;
         end
         GRANT, STALL: begin
            if (wb_stall)   state_next = STALL;
            else if (found) state_next = GRANT;
            else            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Registered grant, mux select, write enable/address and pointer update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         gnt      <= '0;
         wd_sel   <= '0;
         reg_wr   <= 1'b0;
         wr_addr  <= '0;
         busy     <= 1'b0;
         last_ptr <= 3'd5;
      end else begin
         busy <= (state_next != IDLE);
         if (issue) begin
            gnt      <= 6'b1 << winner;
            wd_sel   <= winner;
            wr_addr  <= sel_addr;
            reg_wr   <= (sel_addr != '0);
            last_ptr <= winner;
         end else begin
            gnt    <= '0;
            reg_wr <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter with a behavioural
// round-robin reference model (set WB_LOAD_PRIORITY_EN to match the DUT build).
module tb_wb_arbiter;

`ifdef WB_LOAD_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  req = '0;
   logic [29:0] waddr = '0;
   logic        wb_stall = 1'b0;
   logic [5:0]  gnt;
   logic [2:0]  wd_sel;
   logic        reg_wr;
   logic [4:0]  wr_addr;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model outputs and history.
   logic [5:0] exp_gnt  = '0;
   logic [2:0] exp_sel  = '0;
   logic       exp_wr   = 1'b0;
   logic [4:0] exp_addr = '0;
   logic       exp_busy = 1'b0;
   int         m_last   = 5;

   wb_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .waddr    (waddr),
      .wb_stall (wb_stall),
      .gnt      (gnt),
      .wd_sel   (wd_sel),
      .reg_wr   (reg_wr),
      .wr_addr  (wr_addr),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic tick();
      logic [5:0] e;
      int w;
      bit hit;
      if (!reset) begin
         exp_gnt = '0; exp_sel = '0; exp_wr = 1'b0; exp_addr = '0; exp_busy = 1'b0;
         m_last = 5;
      end else begin
         e = req & ~exp_gnt;
         hit = 1'b0;
         w = 0;
         if (PRIO && e[1]) begin hit = 1'b1; w = 1; end
         for (int k = 1; k <= 6; k++) begin
            if (!hit && e[(m_last + k) % 6]) begin
               hit = 1'b1;
               w = (m_last + k) % 6;
            end
         end
         if (hit && !wb_stall) begin
            exp_gnt  = 6'b1 << w;
            exp_sel  = 3'(w);
            exp_addr = waddr[5*w +: 5];
            exp_wr   = (exp_addr != 5'd0);
            exp_busy = 1'b1;
            m_last   = w;
         end else begin
            exp_gnt  = '0;
            exp_wr   = 1'b0;
            exp_busy = wb_stall && exp_busy;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; req = '0; wb_stall = 1'b0;
      tick(); tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req = 6'h3F; waddr = {6{5'd7}};
      tick(); tick();
      n_checks++;
      if ({gnt, wd_sel, reg_wr, wr_addr, busy} !== {6'h00, 3'd0, 1'b0, 5'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: gnt=%h sel=%0d wr=%b addr=%0d busy=%b, want all zero",
                  gnt, wd_sel, reg_wr, wr_addr, busy);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if (gnt !== 6'h01 || wd_sel !== 3'd0 || reg_wr !== 1'b1) begin
         n_fail++;
         $display("FAIL first_grant: gnt=%h sel=%0d wr=%b, want gnt=01 sel=0 wr=1", gnt, wd_sel, reg_wr);
      end
   endtask

   task automatic test_walk();
      req = 6'h3F;
      for (int i = 0; i < 7; i++) begin
         tick();
         n_checks++;
         if ({gnt, wd_sel, reg_wr, wr_addr, busy} !== {exp_gnt, exp_sel, exp_wr, exp_addr, exp_busy}) begin
            n_fail++;
            $display("FAIL walk[%0d]: gnt=%h sel=%0d wr=%b addr=%0d busy=%b, want %h %0d %b %0d %b",
                     i, gnt, wd_sel, reg_wr, wr_addr, busy, exp_gnt, exp_sel, exp_wr, exp_addr, exp_busy);
         end
      end
   endtask

   task automatic test_mask();
      logic [5:0] prev;
      do_reset();
      req = 6'h04;
      prev = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (gnt !== exp_gnt || reg_wr !== exp_wr || (gnt[2] && prev[2])) begin
            n_fail++;
            $display("FAIL mask[%0d]: gnt=%h prev=%h wr=%b, want gnt=%h wr=%b", i, gnt, prev, reg_wr, exp_gnt, exp_wr);
         end
         prev = gnt;
      end
      req = '0;
      tick();
   endtask

   task automatic test_zero_dest();
      do_reset();
      waddr = '0;
      waddr[29:25] = 5'd31;
      req = 6'h21;
      for (int i = 0; i < 3; i++) begin
         tick();
         req = req & ~gnt;
         n_checks++;
         if ({gnt, wd_sel, reg_wr, wr_addr} !== {exp_gnt, exp_sel, exp_wr, exp_addr}) begin
            n_fail++;
            $display("FAIL zero_dest[%0d]: gnt=%h sel=%0d wr=%b addr=%0d, want %h %0d %b %0d",
                     i, gnt, wd_sel, reg_wr, wr_addr, exp_gnt, exp_sel, exp_wr, exp_addr);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      waddr = {6{5'd9}};
      req = 6'h03;
      tick();
      req = req & ~gnt;
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({gnt, reg_wr, busy} !== {exp_gnt, exp_wr, exp_busy} || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall[%0d]: gnt=%h wr=%b busy=%b, want %h %b %b", i, gnt, reg_wr, busy, exp_gnt, exp_wr, exp_busy);
         end
      end
      wb_stall = 1'b0;
      tick();
      n_checks++;
      if (gnt !== exp_gnt || gnt !== 6'h02 || wd_sel !== 3'd1) begin
         n_fail++;
         $display("FAIL stall_resume: gnt=%h sel=%0d, want %h sel=1", gnt, wd_sel, exp_gnt);
      end
      req = '0;
      tick();
   endtask

   task automatic test_priority();
      do_reset();
      waddr = {6{5'd3}};
      req = 6'h02;
      tick();
      req = 6'h06;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if ({gnt, wd_sel, reg_wr, busy} !== {exp_gnt, exp_sel, exp_wr, exp_busy}) begin
            n_fail++;
            $display("FAIL priority[%0d]: gnt=%h sel=%0d wr=%b busy=%b, want %h %0d %b %b",
                     i, gnt, wd_sel, reg_wr, busy, exp_gnt, exp_sel, exp_wr, exp_busy);
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_random();
      logic [5:0] prev;
      prev = '0;
      for (int i = 0; i < 300; i++) begin
         reset    = ($urandom_range(0, 49) != 0);
         wb_stall = ($urandom_range(0, 4) == 0);
         waddr    = 30'($urandom);
         req      = (req | 6'($urandom & $urandom)) & ~6'($urandom_range(0, 9) == 0 ? $urandom : 0);
         tick();
         req = req & ~gnt;
         n_checks++;
         if ({gnt, wd_sel, reg_wr, wr_addr, busy} !== {exp_gnt, exp_sel, exp_wr, exp_addr, exp_busy}
             || (gnt & prev) != 6'h00 || wd_sel > 3'd5) begin
            n_fail++;
            $display("FAIL random[%0d]: gnt=%h sel=%0d wr=%b addr=%0d busy=%b, want %h %0d %b %0d %b",
                     i, gnt, wd_sel, reg_wr, wr_addr, busy, exp_gnt, exp_sel, exp_wr, exp_addr, exp_busy);
         end
         prev = gnt;
      end
   endtask

   initial begin
      test_reset();
      test_walk();
      test_mask();
      test_zero_dest();
      test_stall();
      test_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
